// File: rtl/decode_queue_pkg.sv
// Shared decode-stage types, opcode constants and the combinational instruction decoder.
package decode_pkg;

  typedef logic [4:0] regind_t;

  localparam regind_t    REG_PC   = 5'd31;
  localparam logic [3:0] OP_OR    = 4'd10;
  localparam logic [3:0] OP_MEMOP = 4'd14;
  localparam logic [3:0] OP_CX    = 4'd15;

  typedef enum logic [1:0] {
    ADJ_ADD   = 2'd0,
    ADJ_LEFT  = 2'd1,
    ADJ_RIGHT = 2'd2,
    ADJ_ARITH = 2'd3
  } adj_t;

  typedef enum logic {ST_RUN = 1'b0, ST_SQUASH = 1'b1} state_t;

  // value is held at 32 bits; the top sign-extends it to XLEN.
  typedef struct packed {
    logic        is_valid;
    logic [3:0]  operation;
    regind_t     dst;
    regind_t     left;
    regind_t     right;
    regind_t     addr;
    adj_t        adj_op;
    logic [31:0] value;
    logic        rd_mem;
    logic        wr_mem;
    logic        pc_chg;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr, input logic [3:0] flags);
    dec_t d;
    d.is_valid  = instr[31] == (|(instr[30:27] & flags));
    d.operation = instr[26:23];
    d.dst       = instr[22:18];
    d.left      = instr[16:12];
    d.right     = instr[11:7];
    d.addr      = instr[15:11];
    d.adj_op    = adj_t'(instr[6:5]);
    d.value     = '0;
    d.rd_mem    = 1'b0;
    d.wr_mem    = 1'b0;
    case (instr[26:23])
      OP_MEMOP: begin
        d.left      = '0;
        d.right     = '0;
        d.operation = OP_OR;
        d.adj_op    = ADJ_ADD;
        case (instr[17:16])
          2'd0: begin
            d.rd_mem = 1'b1;
            d.value  = {{21{instr[10]}}, instr[10:0]};
          end
          2'd1: d.value = {{16{instr[15]}}, instr[15:0]};
          2'd2: begin
            d.left  = instr[22:18];
            d.value = {{16{instr[15]}}, instr[15:0]};
          end
          default: begin
            d.wr_mem = 1'b1;
            d.left   = instr[22:18];
            d.adj_op = ADJ_LEFT;
            d.value  = {{21{instr[10]}}, instr[10:0]};
          end
        endcase
      end
      OP_CX: begin
        d.rd_mem = 1'b1;
        d.wr_mem = 1'b1;
        d.addr   = instr[6:2];
        d.adj_op = ADJ_ADD;
      end
      default: begin
        if (instr[17]) begin
          d.value = {{27{instr[4]}}, instr[4:0]};
        end else begin
          d.right  = '0;
          d.adj_op = ADJ_ADD;
          d.value  = {{20{instr[11]}}, instr[11:0]};
        end
      end
    endcase
    // Pure stores never redirect; loads (including cx) into PC do.
    d.pc_chg = d.is_valid && (!d.wr_mem || d.rd_mem) && (d.dst == REG_PC);
    return d;
  endfunction

endpackage

// File: rtl/decode_queue_fifo.sv
// Count-based circular FIFO with a synchronous clear; a push in the clear cycle lands in slot 0.
module decode_queue_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  always_ff @(posedge clock) begin
    if (push) mem[clear ? '0 : wr_ptr] <= wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= push ? AW'(1) : '0;
      rd_ptr <= '0;
      count  <= (AW+1)'(push);
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/decode_queue.sv
// Decode stage: instruction queue feeding a registered read-stage bundle, with wrong-path squash.
module decode_queue
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic [31:0]     in_instruction,
  input  logic [XLEN-1:0] in_pc,
  output logic            in_ready,
  input  logic [3:0]      flags,
  input  logic            flush,
  input  logic            redirect,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_is_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_operation,
  output logic [4:0]      out_destination_register,
  output logic [4:0]      out_left_register,
  output logic [4:0]      out_right_register,
  output logic [4:0]      out_address_register,
  output logic [1:0]      out_adjustment_operation,
  output logic [XLEN-1:0] out_adjustment_value,
  output logic            out_is_reading_memory,
  output logic            out_is_writing_memory,
  output logic            out_is_pc_changing
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  typedef struct packed {
    dec_t            dec;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] value;
  } bundle_t;

  entry_t                 head, wr_entry;
  dec_t                   head_dec;
  logic signed [XLEN-1:0] head_value;
  bundle_t                out_q;
  state_t                 state;
  logic                   q_empty, q_full;
  logic                   load, accept, squash_edge, q_clear;

  assign wr_entry = '{instr: in_instruction, pc: in_pc};

  decode_queue_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (q_clear),
    .push    (accept),
    .wdata   (wr_entry),
    .pop     (load),
    .rdata   (head),
    .empty   (q_empty),
    .full    (q_full)
  );

  assign head_dec   = decode(head.instr, flags);
  assign head_value = $signed(head_dec.value);

  // In SQUASH fetch is always ready: anything it sends is wrong-path and dropped.
  assign in_ready    = !q_full || (state == ST_SQUASH);
  assign load        = (state == ST_RUN) && !q_empty && (!out_valid || out_ready) && !flush && !redirect;
  assign squash_edge = load && head_dec.pc_chg;
  assign accept      = in_valid && in_ready &&
                       (redirect || ((state == ST_RUN) && !flush && !squash_edge));
  assign q_clear     = flush || redirect || squash_edge;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      out_valid <= 1'b0;
      out_q     <= '0;
    end else begin
      if (flush && !redirect) state <= ST_SQUASH;
      else if (redirect)      state <= ST_RUN;
      else if (squash_edge)   state <= ST_SQUASH;

      if (flush) begin
        out_valid <= 1'b0;
      end else if (load) begin
        out_valid <= 1'b1;
        out_q     <= '{dec: head_dec, pc: head.pc, value: head_value};
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_is_valid             = out_q.dec.is_valid;
  assign out_pc                   = out_q.pc;
  assign out_operation            = out_q.dec.operation;
  assign out_destination_register = out_q.dec.dst;
  assign out_left_register        = out_q.dec.left;
  assign out_right_register       = out_q.dec.right;
  assign out_address_register     = out_q.dec.addr;
  assign out_adjustment_operation = out_q.dec.adj_op;
  assign out_adjustment_value     = out_q.value;
  assign out_is_reading_memory    = out_q.dec.rd_mem;
  assign out_is_writing_memory    = out_q.dec.wr_mem;
  assign out_is_pc_changing       = out_q.dec.pc_chg;

endmodule

// File: tb/tb_decode_queue.sv
// Randomized scoreboard bench for decode_queue against an instruction-level reference model.
module tb_decode_queue;
  import decode_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, flush, redirect, out_valid, out_ready;
  logic [31:0] in_instruction, in_pc, out_pc, out_adjustment_value;
  logic [3:0]  flags, out_operation;
  logic [4:0]  out_destination_register, out_left_register, out_right_register, out_address_register;
  logic [1:0]  out_adjustment_operation;
  logic        out_is_valid, out_is_reading_memory, out_is_writing_memory, out_is_pc_changing;

  decode_queue #(.XLEN(32), .DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_instruction(in_instruction),
    .in_pc(in_pc), .in_ready(in_ready), .flags(flags), .flush(flush), .redirect(redirect),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_valid(out_is_valid), .out_pc(out_pc),
    .out_operation(out_operation), .out_destination_register(out_destination_register),
    .out_left_register(out_left_register), .out_right_register(out_right_register),
    .out_address_register(out_address_register), .out_adjustment_operation(out_adjustment_operation),
    .out_adjustment_value(out_adjustment_value), .out_is_reading_memory(out_is_reading_memory),
    .out_is_writing_memory(out_is_writing_memory), .out_is_pc_changing(out_is_pc_changing)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [3:0]  op;
    logic [4:0]  rd, l, r, a;
    logic [1:0]  adj;
    logic [31:0] val;
    logic        mr, mw, pcc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0, n_acc = 0, n_cons = 0;
  bit   sq = 0, pcc_done = 0, hold_prev = 0;
  exp_t prev;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, want);
  endtask

  function automatic logic [31:0] sx(input logic [31:0] w, input int n);
    int t;
    t = int'(w << (32 - n));
    return 32'(t >>> (32 - n));
  endfunction

  // Instruction-level reference: fields straight from the encoding rules.
  function automatic exp_t ref_model(input logic [31:0] w, input logic [31:0] pc, input logic [3:0] fl);
    exp_t e;
    int   op, mem;
    e     = '0;
    e.pc  = pc;
    e.v   = (w[31] == ((w[30:27] & fl) != 4'd0));
    op    = int'((w >> 23) & 32'hF);
    mem   = int'((w >> 16) & 32'h3);
    e.rd  = 5'((w >> 18) & 32'h1F);
    e.op  = 4'(op);
    e.l   = 5'((w >> 12) & 32'h1F);
    e.r   = 5'((w >> 7) & 32'h1F);
    e.a   = 5'((w >> 11) & 32'h1F);
    e.adj = 2'((w >> 5) & 32'h3);
    if (op == 14) begin
      e.op = 4'd10; e.l = 0; e.r = 0; e.adj = ADJ_ADD;
      if (mem == 0)      begin e.mr = 1; e.val = sx(w, 11); end
      else if (mem == 1) e.val = sx(w, 16);
      else if (mem == 2) begin e.l = e.rd; e.val = sx(w, 16); end
      else               begin e.mw = 1; e.l = e.rd; e.adj = ADJ_LEFT; e.val = sx(w, 11); end
    end else if (op == 15) begin
      e.mr = 1; e.mw = 1; e.a = 5'((w >> 2) & 32'h1F); e.adj = ADJ_ADD; e.val = 0;
    end else if (w[17]) begin
      e.val = sx(w, 5);
    end else begin
      e.r = 0; e.adj = ADJ_ADD; e.val = sx(w, 12);
    end
    e.pcc = e.v && !(e.mw && !e.mr) && (e.rd == 5'd31);
    return e;
  endfunction

  function automatic logic [127:0] all_outs();
    return 128'({out_valid, out_is_valid, out_pc, out_operation, out_destination_register,
                 out_left_register, out_right_register, out_address_register,
                 out_adjustment_operation, out_adjustment_value, out_is_reading_memory,
                 out_is_writing_memory, out_is_pc_changing});
  endfunction

  // Model of acceptance: after an accepted PC-changer, everything is wrong-path until redirect.
  task automatic cyc();
    exp_t e;
    @(negedge clock);
    if (flush) begin
      exp_q.delete();
      sq = !redirect;
    end
    if (redirect) begin
      sq = 0;
      pcc_done = 0;
    end
    if (in_valid && in_ready && !sq) begin
      e = ref_model(in_instruction, in_pc, flags);
      exp_q.push_back(e);
      n_acc++;
      if (e.pcc) sq = 1;
    end
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    exp_t got, e;
    got = {out_is_valid, out_pc, out_operation, out_destination_register, out_left_register,
           out_right_register, out_address_register, out_adjustment_operation,
           out_adjustment_value, out_is_reading_memory, out_is_writing_memory, out_is_pc_changing};
    if (!reset_n) begin
      hold_prev = 0;
    end else begin
      if (hold_prev && out_valid) chk("hold", 128'(got), 128'(prev));
      if (out_valid && out_ready) begin
        n_cons++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_bundle got=%0h exp=none", got);
        end else begin
          e = exp_q.pop_front();
          chk("bundle", 128'(got), 128'(e));
          if (e.pcc) pcc_done = 1;
        end
      end
      hold_prev = out_valid && !out_ready;
      prev = got;
    end
  end

  function automatic logic [31:0] gen();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(3))
      0: w[26:23] = 4'd14;
      1: w[26:23] = 4'd15;
      default: ;
    endcase
    if ($urandom_range(5) == 0) w[22:18] = 5'd31;
    return w;
  endfunction

  function automatic logic [31:0] safe();
    logic [31:0] w;
    w = $urandom;
    w[22:18] = 5'd1;
    return w;
  endfunction

  task automatic push(input logic [31:0] w, input logic [31:0] pc);
    in_valid = 1; in_instruction = w; in_pc = pc;
    cyc();
    in_valid = 0;
  endtask

  initial begin
    int c0, guard;
    logic [31:0] pc;
    reset_n = 0; in_valid = 0; in_instruction = 0; in_pc = 0; flags = 0;
    flush = 0; redirect = 0; out_ready = 1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outs", all_outs(), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    reset_n = 1;

    // ldi r3,#-1: one-edge latency
    push(32'h070DFFFF, 32'h100);
    chk("lat_e0", 128'(out_valid), 128'(0));
    cyc();
    chk("lat_e1", 128'(out_valid), 128'(1));
    chk("ldi_fields", 128'({out_operation, out_left_register, out_right_register, out_destination_register,
                            out_adjustment_operation, out_adjustment_value, out_is_reading_memory, out_is_writing_memory}),
        128'({4'd10, 5'd0, 5'd0, 5'd3, 2'(ADJ_ADD), 32'hFFFFFFFF, 1'b0, 1'b0}));
    // store r5,[r2-1]
    push(32'h071717FF, 32'h104);
    cyc();
    chk("store_fields", 128'({out_is_writing_memory, out_is_reading_memory, out_left_register, out_address_register,
                              out_adjustment_operation, out_adjustment_value}),
        128'({1'b1, 1'b0, 5'd5, 5'd2, 2'(ADJ_LEFT), 32'hFFFFFFFF}));
    cyc();

    // predicate on Z
    push(32'h88040000, 32'h108);
    cyc();
    chk("pred_z0", 128'(out_is_valid), 128'(0));
    repeat (2) cyc();
    flags = 4'b0001;
    push(32'h88040000, 32'h10C);
    cyc();
    chk("pred_z1", 128'(out_is_valid), 128'(1));
    repeat (2) cyc();

    // fill while stalled, then drain with wrap
    out_ready = 0; n_acc = 0;
    in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      in_instruction = safe(); in_pc = 32'h200 + 32'(4 * i);
      cyc();
    end
    in_valid = 0;
    chk("fill_accepted", 128'(n_acc), 128'(5));
    chk("fill_in_ready", 128'(in_ready), 128'(0));
    c0 = n_cons;
    out_ready = 1;
    repeat (8) cyc();
    chk("fill_drained", 128'(n_cons - c0), 128'(5));

    // ldi PC then wrong-path pushes, then redirect
    push(32'h077D0100, 32'h300);
    in_valid = 1; in_instruction = safe(); in_pc = 32'h304;
    cyc();
    chk("pcc_flag", 128'({out_valid, out_is_pc_changing}), 128'(2'b11));
    in_instruction = safe(); in_pc = 32'h308;
    cyc();
    in_valid = 0;
    chk("squash_ov_low", 128'(out_valid), 128'(0));
    cyc();
    chk("squash_quiet", 128'(out_valid), 128'(0));
    redirect = 1;
    push(32'h01880005, 32'h400);
    redirect = 0;
    cyc();
    chk("redirect_next", 128'({out_valid, out_pc}), 128'({1'b1, 32'h400}));
    repeat (2) cyc();

    // flush with queued entries and a concurrent push
    out_ready = 0;
    for (int i = 0; i < 4; i++) push(safe(), 32'h500 + 32'(4 * i));
    flush = 1;
    push(safe(), 32'h510);
    flush = 0;
    chk("flush_ov", 128'(out_valid), 128'(0));
    out_ready = 1; c0 = n_cons;
    repeat (4) cyc();
    chk("flush_quiet", 128'(n_cons - c0), 128'(0));
    redirect = 1;
    cyc();
    redirect = 0;

    // asynchronous reset mid-stream
    out_ready = 0;
    push(safe(), 32'h600);
    push(safe(), 32'h604);
    #2;
    reset_n = 0;
    #1;
    chk("async_reset", all_outs(), 128'(0));
    exp_q.delete(); sq = 0; pcc_done = 0;
    @(posedge clock);
    #1;
    reset_n = 1;
    chk("post_reset_ready", 128'(in_ready), 128'(1));

    // randomized phases, flags fixed per phase
    pc = 32'h1000;
    for (int ph = 0; ph < 3; ph++) begin
      flags = 4'($urandom);
      for (int i = 0; i < 300; i++) begin
        in_valid = ($urandom_range(3) != 0);
        in_instruction = gen();
        in_pc = pc; pc += 4;
        out_ready = ($urandom_range(3) != 0);
        redirect = sq && pcc_done && ($urandom_range(1) == 1);
        cyc();
      end
      in_valid = 0; out_ready = 1; redirect = 0;
      guard = 0;
      while ((exp_q.size() != 0 || sq) && guard < 60) begin
        redirect = sq && pcc_done;
        cyc();
        redirect = 0;
        guard++;
      end
      if (guard >= 60) begin
        n_chk++;
        $display("FAIL drain_timeout got=%0d pending exp=0", exp_q.size());
        exp_q.delete(); sq = 0;
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor decode stage. Sits between fetch and register read.
- An internal DEPTH-entry instruction queue decouples fetch from read-stage stalls.
- Decodes the queue head into a registered read-stage bundle. Each entry carries its own PC.
- Squashes wrong-path instructions after a PC-changing instruction until fetch signals redirect.

Parameters:
XLEN, 32, register/PC/adjustment-value width (≥32)
DEPTH, 4, queue entries (power of two, ≥2)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch offers an instruction
in_instruction  in  32  instruction word
in_pc  in  XLEN  PC of in_instruction
in_ready  out  1  queue accepts this cycle
flags  in  4  {C,N,V,Z} = Flags register bits 30:27
flush  in  1  downstream kill: drop queue and output
redirect  in  1  fetch has restarted at a new PC
out_valid  out  1  output bundle present
out_ready  in  1  read stage consumes bundle (replaces hold)
out_is_valid  out  1  predicate passed
out_pc  out  XLEN  entry PC
out_operation  out  4  ALU op
out_destination_register, out_left_register, out_right_register, out_address_register  out  5 each
out_adjustment_operation  out  2
out_adjustment_value  out  XLEN
out_is_reading_memory, out_is_writing_memory  out  1 each
out_is_pc_changing  out  1  to fetch: this bundle redirects PC

Behaviour:
- Reset is asynchronous. All outputs are 0, the queue is empty, and the state is RUN. reset_n falling mid-stream discards everything immediately.
- Push: in_valid && in_ready at an edge. in_ready = (count<DEPTH) || state==SQUASH. There is no pass-through when the queue is full.
- Load: the output register loads the decoded head when state==RUN, the queue is non-empty, and (!out_valid || out_ready). The load pops the head.
- If out_ready is high and there is no load, out_valid falls.
- Latency: push at edge E0 gives out_valid at E1 (minimum 1 edge, empty queue).
- Hold: out_valid && !out_ready keeps all out_* stable.
- Predicate: masked = |(cnvz_mask & flags), evaluated with flags at load time. is_valid = (instr[31] == masked). Invalid instructions are still emitted with out_is_valid=0.
- Fields:
  - cnvz_mask = [30:27], op = [26:23], rd = [22:18], is_reg = [17], sr1 = [16:12], sr2 = [11:7]
  - adj_op = [6:5], adj_val = [4:0], imm12 = [11:0], mem_op = [17:16]
  - addr = [15:11], off11 = [10:0], imm16 = [15:0], cx_addr = [6:2]
  - All immediates are sign-extended to XLEN.
- Default mapping: left=sr1, right=sr2, address=addr, operation=op, adjustment_op=adj_op.
- op 14: left=0, right=0, operation=OR(10), adjustment_op=Add. Then by mem_op:
  - 0 (ld): read=1, value=sext(off11)
  - 1 (ldi): value=sext(imm16)
  - 2 (ori): left=rd, value=sext(imm16)
  - 3 (store): write=1, left=rd, adjustment_op=Left, value=sext(off11)
- op 15 (cx): read=1, write=1, address=cx_addr, adjustment_op=Add, value=0.
- Other ops:
  - is_reg=1: value=sext(adj_val).
  - Otherwise: right=0, adjustment_op=Add, value=sext(imm12).
- pc_changing = is_valid && (!write || read) && rd==PC.
- State machine (RUN, SQUASH):
  - RUN→SQUASH when a load has pc_changing. That edge empties the queue and drops any concurrent push. The loaded bundle itself is still emitted.
  - SQUASH: pushes are dropped (in_ready=1) and there are no loads.
  - SQUASH→RUN on redirect. A push in the redirect cycle is accepted as the first new-stream instruction.
- flush: at the edge, empties the queue, clears out_valid, and enters SQUASH. A concurrent push is dropped unless redirect is also high.
- flush && redirect: queue and out_valid cleared, state RUN, concurrent push accepted.
- redirect in RUN: the queue is emptied, then the concurrent push is accepted.

Decomposition:
- Shared package decode_pkg holds:
  - regind_t, the PC register index, the opcode constants (OR=10, MEMOP=14, CX=15), and the adjustment enum (Add, Left, …)
  - a decoded-bundle struct parameterised by XLEN via the module
  - a pure decode function (instruction, flags) → bundle
- One sub-module: decode_queue_fifo. It stores {instruction, pc} with count-based full/empty, a clear input, and wrap-around pointers.

Test Plan:
1. Empty queue, push 0x070DFFFF (ldi r3,#-1) with out_ready=1 → next edge: out_valid=1, operation=10, left=0, right=0, destination=3, adjustment_op=Add, value=0xFFFFFFFF, read=0, write=0.
2. Push 0x071717FF (store r5,[r2-1]) → write=1, read=0, left=5, address=2, adjustment_op=Left, value=0xFFFFFFFF.
3. Predicate: instr bit31=1, mask=Z, flags=4'b0000 → out_is_valid=0. Same instruction with flags Z=1 → out_is_valid=1.
4. out_ready=0 with 6 back-to-back pushes (DEPTH=4) → 5 accepted, in_ready=0 afterwards. Release out_ready → 5 bundles emitted in order with correct out_pc, and the queue wraps.
5. ldi PC followed by 2 pushes → out_is_pc_changing=1 on the ldi. The following pushes are dropped and out_valid falls. redirect together with a push of a new instruction → that instruction emitted next.
6. flush with 3 entries queued and a push in the same cycle → out_valid=0, nothing emitted. Assert reset_n low mid-stream → all outputs 0 immediately, in_ready=1 after release.
